// File: rtl/ipx_testx_sched.sv
// ipx_testx_sched -- test scheduler and shared-datapath controller for the
// ipX_testY test state machines of the CMS pix28 test firmware.
//
// Picks one of N_TESTS test FSMs, enables it and gives it a one-cycle start
// pulse. It also owns the resources the test FSMs share:
//   - the config-clock phase counter and the fast config clock
//   - the pattern shift register and its shift counter
//   - the aggregated busy / done / error status
//
// Optional build macro: CMS_PIX28_SCHED_PRBS_EN
//   - When defined, a shift steps a PRBS-7 (x^7+x^6+1) held in sr[6:0].
//   - When undefined, a shift rotates the whole register right.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   test_sel, test_start     test index, and a level whose rising edge starts a test
//   clk_div                  config-clock period minus 1
//   pattern, shift_cnt_max   shift-register load value, and the shift count limit
//   tst_shift_reg_load/shift per-test shift-register requests
//   tst_status_done          per-test completion flags
//   test_enable(_re)         one-hot enable, and the start pulse, to the selected test
//   clk_counter              config-clock phase
//   fast_config_clk          config clock
//   shift_reg_bit0           LSB of the shift register
//   shift_reg_shift_cnt      shifts executed since the last load
//   status_busy/done/error   aggregated status (done and error are sticky)
module ipx_testx_sched #(
    parameter int N_TESTS = 4,
    parameter int SR_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         test_sel,
    input  logic               test_start,
    input  logic [6:0]         clk_div,
    input  logic [SR_W-1:0]    pattern,
    input  logic [13:0]        shift_cnt_max,
    input  logic [N_TESTS-1:0] tst_shift_reg_load,
    input  logic [N_TESTS-1:0] tst_shift_reg_shift,
    input  logic [N_TESTS-1:0] tst_status_done,
    output logic [N_TESTS-1:0] test_enable,
    output logic [N_TESTS-1:0] test_enable_re,
    output logic [6:0]         clk_counter,
    output logic               fast_config_clk,
    output logic               shift_reg_bit0,
    output logic [13:0]        shift_reg_shift_cnt,
    output logic               status_busy,
    output logic               status_done,
    output logic               status_error
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [4:0] N_TESTS_W = 5'(N_TESTS);

    state_t             state_reg;
    logic [3:0]         sel_reg;
    logic               test_start_d_reg;
    logic [N_TESTS-1:0] enable_reg;
    logic [N_TESTS-1:0] enable_re_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;
    logic [6:0]         clk_counter_reg;
    logic [6:0]         clk_counter_next;
    logic               fast_clk_reg;
    logic [SR_W-1:0]    sr_reg;
    logic [SR_W-1:0]    sr_load_val;
    logic [SR_W-1:0]    sr_shift_val;
    logic [13:0]        shift_cnt_reg;

    logic [N_TESTS-1:0] sel_hot;     // one-hot of the latched selection
    logic [N_TESTS-1:0] req_hot;     // one-hot of the incoming test_sel
    logic               start_re;
    logic               sel_valid;
    logic               arm_now;
    logic               load_req;
    logic               shift_req;
    logic               done_req;
    logic [7:0]         half_period;

    genvar gi;
    generate
        for (gi = 0; gi < N_TESTS; gi++) begin : g_sel
            assign sel_hot[gi] = (sel_reg == 4'(gi));
            assign req_hot[gi] = (test_sel == 4'(gi));
        end
    endgenerate

    assign start_re  = test_start & ~test_start_d_reg;
    assign sel_valid = ({1'b0, test_sel} < N_TESTS_W);
    assign arm_now   = (state_reg == IDLE) && start_re && sel_valid;

    // Only the selected test may drive the shared shift register, and only
    // while it is enabled; every other request bit is masked off here.
    assign load_req  = |(tst_shift_reg_load  & sel_hot & enable_reg);
    assign shift_req = |(tst_shift_reg_shift & sel_hot & enable_reg);
    assign done_req  = |(tst_status_done & sel_hot);

    // Threshold at which the config clock goes high. It is computed in 8 bits,
    // so clk_div = 127 does not overflow.
    assign half_period = ({1'b0, clk_div} + 8'd1) >> 1;

    // Using >= rather than == means a counter that is already beyond a newly
    // lowered clk_div wraps on the next cycle. The counter is zeroed on entry
    // to ARM, so it reads 0 for the whole ARM cycle.
    always_comb begin
        if (arm_now) begin
            clk_counter_next = 7'd0;
        end else if (clk_counter_reg >= clk_div) begin
            clk_counter_next = 7'd0;
        end else begin
            clk_counter_next = clk_counter_reg + 7'd1;
        end
    end

    always_comb begin
        sr_load_val  = pattern;
        sr_shift_val = {sr_reg[0], sr_reg[SR_W-1:1]};
`ifdef CMS_PIX28_SCHED_PRBS_EN
        sr_shift_val      = sr_reg;
        sr_shift_val[6:0] = {sr_reg[5:0], sr_reg[6] ^ sr_reg[5]};
        // An all-zero seed would lock the LFSR up, so it is replaced by 1.
        if (pattern[6:0] == 7'd0) begin
            sr_load_val[6:0] = 7'h01;
        end
`endif
    end

    // Sequencer. Outputs are registered and are updated on the transition
    // into each state, so test_enable appears one clk after the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            sel_reg          <= 4'd0;
            test_start_d_reg <= 1'b0;
            enable_reg       <= '0;
            enable_re_reg    <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            test_start_d_reg <= test_start;
            case (state_reg)
                IDLE: begin
                    if (start_re) begin
                        if (sel_valid) begin
                            state_reg  <= ARM;
                            sel_reg    <= test_sel;
                            enable_reg <= req_hot;
                            busy_reg   <= 1'b1;
                            done_reg   <= 1'b0;
                            error_reg  <= 1'b0;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    state_reg     <= RUN;
                    enable_re_reg <= sel_hot;
                end
                RUN: begin
                    enable_re_reg <= '0;
                    // An abort is checked first, so it wins over a done seen
                    // in the same cycle.
                    if (!test_start) begin
                        state_reg  <= IDLE;
                        enable_reg <= '0;
                        busy_reg   <= 1'b0;
                        error_reg  <= 1'b1;
                    end else if (done_req) begin
                        state_reg  <= DONE;
                        enable_reg <= '0;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Shared datapath: the config clock and the pattern shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_counter_reg <= 7'd0;
            fast_clk_reg    <= 1'b0;
            sr_reg          <= '0;
            shift_cnt_reg   <= 14'd0;
        end else begin
            clk_counter_reg <= clk_counter_next;
            // Computed from the next count, so the clock level lines up with
            // the clk_counter value shown alongside it.
            fast_clk_reg    <= ({1'b0, clk_counter_next} >= half_period);
            if (load_req) begin
                sr_reg        <= sr_load_val;
                shift_cnt_reg <= 14'd0;
            end else if (shift_req) begin
                sr_reg <= sr_shift_val;
                if ((shift_cnt_reg < shift_cnt_max) && (shift_cnt_reg != 14'h3FFF)) begin
                    shift_cnt_reg <= shift_cnt_reg + 14'd1;
                end
            end
        end
    end

    assign test_enable         = enable_reg;
    assign test_enable_re      = enable_re_reg;
    assign clk_counter         = clk_counter_reg;
    assign fast_config_clk     = fast_clk_reg;
    assign shift_reg_bit0      = sr_reg[0];
    assign shift_reg_shift_cnt = shift_cnt_reg;
    assign status_busy         = busy_reg;
    assign status_done         = done_reg;
    assign status_error        = error_reg;

endmodule
